// File: rtl/freq_meter.sv
// Gated frequency counter: counts synchronized rising edges of sig_in over GATE_CYCLES clocks.
// Optional build macro FM_BCD_EN adds a sequential binary-to-BCD converter on each published count.
module freq_meter #(
    parameter int GATE_CYCLES = 50,
    parameter int CNT_W       = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq_cnt,
    output logic             freq_vld,
    output logic             freq_ovf,
    output logic             busy
`ifdef FM_BCD_EN
    ,
    output logic [23:0]      freq_bcd,
    output logic             bcd_vld
`endif
);

    localparam int GATE_W = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic {
        ST_IDLE,
        ST_GATE
    } state_e;

    state_e              state_q, state_d;
    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic                prev_q, prev_d;
    logic [GATE_W-1:0]   gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0]    edge_cnt_q, edge_cnt_d;
    logic                sat_q, sat_d;
    logic [CNT_W-1:0]    freq_cnt_q, freq_cnt_d;
    logic                freq_ovf_q, freq_ovf_d;
    logic                freq_vld_q, freq_vld_d;

    logic                edge_det;
    logic                edge_inc;
    logic [CNT_W-1:0]    edge_nxt;
    logic                sat_nxt;

    always_comb begin
        state_d    = state_q;
        sync1_d    = sig_in;
        sync2_d    = sync1_q;
        prev_d     = sync2_q;
        gate_cnt_d = gate_cnt_q;
        edge_cnt_d = edge_cnt_q;
        sat_d      = sat_q;
        freq_cnt_d = freq_cnt_q;
        freq_ovf_d = freq_ovf_q;
        freq_vld_d = 1'b0;

        // Count including this cycle's edge, so the terminal cycle's edge lands in the closing window.
        edge_det = sync2_q & ~prev_q;
        edge_inc = edge_det && (edge_cnt_q != CNT_MAX);
        edge_nxt = edge_cnt_q + CNT_W'(edge_inc);
        sat_nxt  = sat_q | (edge_nxt == CNT_MAX);

        case (state_q)
            ST_IDLE: begin
                gate_cnt_d = '0;
                edge_cnt_d = '0;
                sat_d      = 1'b0;
                if (en) state_d = ST_GATE;
            end
            ST_GATE: begin
                if (!en) begin
                    state_d    = ST_IDLE;
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                    sat_d      = 1'b0;
                end else if (gate_cnt_q == GATE_LAST) begin
                    freq_cnt_d = edge_nxt;
                    freq_ovf_d = sat_nxt;
                    freq_vld_d = 1'b1;
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                    sat_d      = 1'b0;
                end else begin
                    gate_cnt_d = gate_cnt_q + GATE_W'(1);
                    edge_cnt_d = edge_nxt;
                    sat_d      = sat_nxt;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            prev_q     <= 1'b0;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
            freq_cnt_q <= '0;
            freq_ovf_q <= 1'b0;
            freq_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            sat_q      <= sat_d;
            freq_cnt_q <= freq_cnt_d;
            freq_ovf_q <= freq_ovf_d;
            freq_vld_q <= freq_vld_d;
        end
    end

    assign freq_cnt = freq_cnt_q;
    assign freq_vld = freq_vld_q;
    assign freq_ovf = freq_ovf_q;
    assign busy     = (state_q == ST_GATE);

`ifdef FM_BCD_EN
    localparam int          CC_W    = $clog2(CNT_W + 1);
    localparam logic [31:0] BCD_MAX = 32'd999999;

    logic              conv_act_q, conv_act_d;
    logic [CC_W-1:0]   conv_cnt_q, conv_cnt_d;
    logic [CNT_W-1:0]  bin_q, bin_d;
    logic [23:0]       work_q, work_d;
    logic [23:0]       freq_bcd_q, freq_bcd_d;
    logic              bcd_vld_q, bcd_vld_d;
    logic [23:0]       adj;

    // Load on the publish edge, CNT_W shift-add-3 steps, then one cycle to present the result.
    always_comb begin
        conv_act_d = conv_act_q;
        conv_cnt_d = conv_cnt_q;
        bin_d      = bin_q;
        work_d     = work_q;
        freq_bcd_d = freq_bcd_q;
        bcd_vld_d  = 1'b0;

        adj = work_q;
        for (int i = 0; i < 6; i++) begin
            if (work_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
        end

        if (!en) begin
            conv_act_d = 1'b0;
        end else if (freq_vld_d) begin
            conv_act_d = 1'b1;
            conv_cnt_d = '0;
            work_d     = '0;
            if (CNT_W >= 20 && 32'(freq_cnt_d) > BCD_MAX) bin_d = CNT_W'(BCD_MAX);
            else bin_d = freq_cnt_d;
        end else if (conv_act_q) begin
            if (conv_cnt_q == CC_W'(CNT_W)) begin
                conv_act_d = 1'b0;
                freq_bcd_d = work_q;
                bcd_vld_d  = 1'b1;
            end else begin
                work_d     = {adj[22:0], bin_q[CNT_W-1]};
                bin_d      = bin_q << 1;
                conv_cnt_d = conv_cnt_q + CC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            conv_act_q <= 1'b0;
            conv_cnt_q <= '0;
            bin_q      <= '0;
            work_q     <= '0;
            freq_bcd_q <= '0;
            bcd_vld_q  <= 1'b0;
        end else begin
            conv_act_q <= conv_act_d;
            conv_cnt_q <= conv_cnt_d;
            bin_q      <= bin_d;
            work_q     <= work_d;
            freq_bcd_q <= freq_bcd_d;
            bcd_vld_q  <= bcd_vld_d;
        end
    end

    assign freq_bcd = freq_bcd_q;
    assign bcd_vld  = bcd_vld_q;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: two instances (wide and 4-bit counter) share stimulus and are checked
// every cycle against a window-level model, plus directed literal checks.
module tb_freq_meter;

    localparam int GC   = 50;
    localparam int WA   = 20;
    localparam int WB   = 4;
    localparam int MAXA = (1 << WA) - 1;
    localparam int MAXB = (1 << WB) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic sig_in = 1'b0;

    logic [WA-1:0] a_cnt;
    logic          a_vld, a_ovf, a_busy;
    logic [WB-1:0] b_cnt;
    logic          b_vld, b_ovf, b_busy;
`ifdef FM_BCD_EN
    logic [23:0]   a_bcd, b_bcd;
    logic          a_bv, b_bv;
`endif

    freq_meter #(.GATE_CYCLES(GC), .CNT_W(WA)) u_dut_a (
        .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
        .freq_cnt(a_cnt), .freq_vld(a_vld), .freq_ovf(a_ovf), .busy(a_busy)
`ifdef FM_BCD_EN
        , .freq_bcd(a_bcd), .bcd_vld(a_bv)
`endif
    );

    freq_meter #(.GATE_CYCLES(GC), .CNT_W(WB)) u_dut_b (
        .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
        .freq_cnt(b_cnt), .freq_vld(b_vld), .freq_ovf(b_ovf), .busy(b_busy)
`ifdef FM_BCD_EN
        , .freq_bcd(b_bcd), .bcd_vld(b_bv)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stimulus source for sig_in: 0 hold, 1 square wave, 2 random with density percent.
    int sig_mode = 0;
    int hold_val = 0;
    int period   = 10;
    int dens     = 50;
    int phase    = 0;

    always @(negedge clk) begin
        phase++;
        case (sig_mode)
            0: sig_in = (hold_val != 0);
            1: sig_in = ((phase % period) < (period / 2));
            default: sig_in = ($urandom_range(0, 99) < dens);
        endcase
    end

    function automatic logic [23:0] to_bcd(input int v);
        logic [23:0] r;
        int x;
        x = (v > 999999) ? 999999 : v;
        r = '0;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Window-level model: count of synchronized rising edges per gate window, unbounded, clamped on publish.
    bit h0, h1, h2;
    bit in_gate;
    int pos, count;
    int ea_cnt, eb_cnt;
    bit ea_ovf, eb_ovf, e_vld, e_busy;
`ifdef FM_BCD_EN
    bit pa, pb, ea_bv, eb_bv;
    int wa, wb;
    logic [23:0] va, vb, ea_bcd, eb_bcd;
`endif

    always @(posedge clk) begin
        bit e;
        e = h1 & ~h2;
        e_vld = 0;
`ifdef FM_BCD_EN
        ea_bv = 0;
        eb_bv = 0;
`endif
        if (rst) begin
            h0 = 0; h1 = 0; h2 = 0;
            in_gate = 0; pos = 0; count = 0;
            ea_cnt = 0; eb_cnt = 0; ea_ovf = 0; eb_ovf = 0;
`ifdef FM_BCD_EN
            pa = 0; pb = 0; ea_bcd = '0; eb_bcd = '0;
`endif
        end else begin
            h2 = h1; h1 = h0; h0 = sig_in;
`ifdef FM_BCD_EN
            if (!en) begin
                pa = 0; pb = 0;
            end else begin
                if (pa) begin
                    wa--;
                    if (wa == 0) begin pa = 0; ea_bcd = va; ea_bv = 1; end
                end
                if (pb) begin
                    wb--;
                    if (wb == 0) begin pb = 0; eb_bcd = vb; eb_bv = 1; end
                end
            end
`endif
            if (!en) begin
                in_gate = 0; pos = 0; count = 0;
            end else if (!in_gate) begin
                in_gate = 1; pos = 0; count = 0;
            end else begin
                count += int'(e);
                if (pos == GC - 1) begin
                    e_vld  = 1;
                    ea_cnt = (count > MAXA) ? MAXA : count;
                    eb_cnt = (count > MAXB) ? MAXB : count;
                    ea_ovf = (count >= MAXA);
                    eb_ovf = (count >= MAXB);
`ifdef FM_BCD_EN
                    pa = 1; wa = WA + 1; va = to_bcd(ea_cnt);
                    pb = 1; wb = WB + 1; vb = to_bcd(eb_cnt);
`endif
                    pos = 0; count = 0;
                end else begin
                    pos++;
                end
            end
        end
        e_busy = in_gate;
        #1;
        chk("a_cnt", 32'(a_cnt), 32'(ea_cnt));
        chk("a_vld", 32'(a_vld), 32'(e_vld));
        chk("a_ovf", 32'(a_ovf), 32'(ea_ovf));
        chk("a_busy", 32'(a_busy), 32'(e_busy));
        chk("b_cnt", 32'(b_cnt), 32'(eb_cnt));
        chk("b_vld", 32'(b_vld), 32'(e_vld));
        chk("b_ovf", 32'(b_ovf), 32'(eb_ovf));
        chk("b_busy", 32'(b_busy), 32'(e_busy));
`ifdef FM_BCD_EN
        chk("a_bcd", 32'(a_bcd), 32'(ea_bcd));
        chk("a_bcd_vld", 32'(a_bv), 32'(ea_bv));
        chk("b_bcd", 32'(b_bcd), 32'(eb_bcd));
        chk("b_bcd_vld", 32'(b_bv), 32'(eb_bv));
`endif
    end

    // Waits for the n-th freq_vld of instance a; a timeout is a failed comparison.
    task automatic wait_vld(input int nth, input string name);
        int seen = 0;
        int cyc = 0;
        while (seen < nth && cyc < 400) begin
            @(posedge clk);
            #2;
            cyc++;
            if (a_vld) seen++;
        end
        if (seen < nth) chk({name, "_timeout"}, 32'(seen), 32'(nth));
    endtask

    task automatic set_wave(input int mode, input int p, input int hv);
        @(negedge clk);
        sig_mode = mode;
        period   = p;
        hold_val = hv;
    endtask

    int off_cnt = 0;
    int n;

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        chk("rst_cnt", 32'(a_cnt), 32'd0);
        chk("rst_vld_busy", {30'd0, a_vld, a_busy}, 32'd0);

        // Square wave, period 10: five edges per window.
        set_wave(1, 10, 0);
        rst = 1'b0;
        en  = 1'b1;
        wait_vld(3, "sq10");
        chk("sq10_cnt", 32'(a_cnt), 32'd5);
        chk("sq10_ovf", 32'(a_ovf), 32'd0);
`ifdef FM_BCD_EN
        n = 0;
        while (!a_bv && n < 40) begin @(posedge clk); #2; n++; end
        chk("sq10_bcd_lat", 32'(n), 32'(WA + 1));
        chk("sq10_bcd", 32'(a_bcd), 32'h000005);
`endif

        // Period 2 saturates the 4-bit instance.
        set_wave(1, 2, 0);
        wait_vld(3, "sq2");
        chk("sq2_a_cnt", 32'(a_cnt), 32'd25);
        chk("sq2_b_cnt", 32'(b_cnt), 32'd15);
        chk("sq2_b_ovf", 32'(b_ovf), 32'd1);
        set_wave(1, 10, 0);
        wait_vld(3, "sq10b");
        chk("sq10b_b_cnt", 32'(b_cnt), 32'd5);
        chk("sq10b_b_ovf", 32'(b_ovf), 32'd0);

        // Static input levels.
        set_wave(0, 10, 0);
        wait_vld(3, "lo");
        chk("lo_cnt", 32'(a_cnt), 32'd0);
        set_wave(0, 10, 1);
        wait_vld(3, "hi");
        chk("hi_cnt", 32'(a_cnt), 32'd0);

        // Abort at gate count 20, idle 10 cycles, then a fresh full window.
        set_wave(1, 10, 0);
        wait_vld(2, "abort_pre");
        repeat (21) @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #2;
        chk("abort_busy", 32'(a_busy), 32'd0);
        chk("abort_hold_cnt", 32'(a_cnt), 32'd5);
        repeat (10) @(negedge clk);
        en = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!a_vld && n < 200);
        chk("reen_latency", 32'(n), 32'd51);
        chk("reen_cnt", 32'(a_cnt), 32'd5);

        // One-cycle reset mid-window.
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;
        chk("mid_rst_cnt", 32'(a_cnt), 32'd0);
        chk("mid_rst_vld_busy", {30'd0, a_vld, a_busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_vld(2, "post_rst");
        chk("post_rst_cnt", 32'(a_cnt), 32'd5);

        // Randomized input, enable drops and rare resets.
        sig_mode = 2;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (k % 500 == 0) dens = $urandom_range(20, 80);
            if (off_cnt > 0) begin
                off_cnt--;
                en = 1'b0;
            end else begin
                en = 1'b1;
                if ($urandom_range(0, 299) == 0) off_cnt = $urandom_range(1, 60);
            end
            rst = ($urandom_range(0, 999) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
